// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache controller.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_e;

    localparam int unsigned LINES_DEF = 64;
    localparam int unsigned WORDS_DEF = 4;
    localparam int unsigned OB        = $clog2(WORDS_DEF);
    localparam int unsigned IB        = $clog2(LINES_DEF);
    localparam int unsigned TB        = 16 - OB - IB;

endpackage

// File: rtl/icache_if.sv
// Fetch port and line-fill bus of the instruction cache; slave = cache side.
interface icache_if;
    logic [15:0] i_addr;
    logic [15:0] instr;
    logic        i_hit;
    logic        inv;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_vld;
    logic [15:0] mem_rdata;

    modport slave (
        input  i_addr, inv, mem_ack, mem_vld, mem_rdata,
        output instr, i_hit, mem_re, mem_addr
    );

    modport master (
        output i_addr, inv, mem_ack, mem_vld, mem_rdata,
        input  instr, i_hit, mem_re, mem_addr
    );
endinterface

// File: rtl/icache_data_array.sv
// Cache data storage: LINES*WORDS x 16, async read, one sync write, no reset.
module icache_data_array #(
    parameter int unsigned LINES = 64,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] widx,
    input  logic [$clog2(WORDS)-1:0] woff,
    input  logic [15:0]              wdata,
    input  logic [$clog2(LINES)-1:0] ridx,
    input  logic [$clog2(WORDS)-1:0] roff,
    output logic [15:0]              rdata
);

    logic [15:0] mem_q [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{widx, woff}] <= wdata;
        end
    end

    assign rdata = mem_q[{ridx, roff}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with line-fill FSM.
// Optional ICACHE_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEF,
    parameter int unsigned WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int unsigned OB_W = $clog2(WORDS);
    localparam int unsigned IB_W = $clog2(LINES);
    localparam int unsigned TB_W = 16 - OB_W - IB_W;
    localparam logic [OB_W-1:0] LAST_BEAT = OB_W'(WORDS - 1);

    state_e                 state_q, state_d;
    logic [TB_W+IB_W-1:0]   miss_q, miss_d;
    logic [OB_W-1:0]        beat_q, beat_d;
    logic                   pend_q, pend_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TB_W-1:0]        tag_q [LINES];

    logic [OB_W-1:0]        off;
    logic [IB_W-1:0]        idx;
    logic [TB_W-1:0]        tag;
    logic [IB_W-1:0]        miss_idx;
    logic [TB_W-1:0]        miss_tag;
    logic                   hit;
    logic                   data_we;
    logic                   tag_we;
    logic [15:0]            rdata;

    assign off      = bus.i_addr[OB_W-1:0];
    assign idx      = bus.i_addr[OB_W +: IB_W];
    assign tag      = bus.i_addr[OB_W+IB_W +: TB_W];
    assign miss_idx = miss_q[IB_W-1:0];
    assign miss_tag = miss_q[IB_W +: TB_W];

    assign hit          = (state_q == S_IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign bus.i_hit    = hit;
    assign bus.instr    = hit ? rdata : '0;
    assign bus.mem_re   = (state_q == S_REQ);
    assign bus.mem_addr = {miss_q, {OB_W{1'b0}}};

    icache_data_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data (
        .clk   (clk),
        .we    (data_we),
        .widx  (miss_idx),
        .woff  (beat_q),
        .wdata (bus.mem_rdata),
        .ridx  (idx),
        .roff  (off),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        data_we = 1'b0;
        tag_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (!hit) begin
                    miss_d  = {tag, idx};
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.inv)     pend_d  = 1'b1;
                if (bus.mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                if (bus.inv) pend_d = 1'b1;
                if (bus.mem_vld) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + OB_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        beat_d  = '0;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                        // An invalidate seen at any point of the fill leaves the line invalid.
                        if (!pend_q && !bus.inv) valid_d[miss_idx] = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.inv) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            miss_q  <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[miss_idx] <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (state_q == S_IDLE && state_d == S_REQ && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
